// File: rtl/dff_using_tff_reg.sv
// Multi-bit register built only from T flip-flop cells, exposing LOAD/TOGGLE/COUNT/CLEAR
// commands over a valid/ready handshake, with a saturating toggle-activity counter.
module dff_using_tff_reg #(
  parameter int WIDTH  = 8,
  parameter int TCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [7:0]        cmd_len,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  t_vec,
  output logic              busy,
  output logic              done,
  input  logic              tcnt_clr,
  output logic [TCNT_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b11;
  localparam int         PC_W      = $clog2(WIDTH + 1);

  state_t              state_reg, state_next;
  logic [7:0]          remaining_reg, remaining_next;
  logic [WIDTH-1:0]    q_reg;
  logic [WIDTH-1:0]    t;
  logic [WIDTH-1:0]    inc_t;
  logic [WIDTH-1:0]    t_vec_reg;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
  logic [TCNT_W:0]     tcnt_sum;
  logic [PC_W-1:0]     t_pop;
  logic                accept;

  assign cmd_ready = (state_reg == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // One T cell per bit; the increment vector is the classic synchronous-counter carry chain.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tcell
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg[gi] <= 1'b0;
        end else begin
          q_reg[gi] <= q_reg[gi] ^ t[gi];
        end
      end

      if (gi == 0) begin : g_lsb
        assign inc_t[gi] = 1'b1;
      end else begin : g_upper
        assign inc_t[gi] = &q_reg[gi-1:0];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    t              = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = DONE;
          case (cmd_op)
            OP_LOAD:   t = cmd_data ^ q_reg;
            OP_TOGGLE: t = cmd_data;
            OP_CLEAR:  t = q_reg;
            default: begin
              if (cmd_len != 8'd0) begin
                remaining_next = cmd_len;
                state_next     = COUNT;
              end
            end
          endcase
        end
      end
      COUNT: begin
        t              = inc_t;
        remaining_next = remaining_reg - 8'd1;
        if (remaining_reg == 8'd1) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    t_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_pop = t_pop + PC_W'(t[i]);
    end
  end

  // Carry out of the widened sum means the counter would pass its ceiling.
  assign tcnt_sum = {1'b0, tcnt_reg} + (TCNT_W + 1)'(t_pop);

  always_comb begin
    tcnt_next = tcnt_reg;
    if (tcnt_clr) begin
      tcnt_next = '0;
    end else if (tcnt_sum[TCNT_W]) begin
      tcnt_next = '1;
    end else begin
      tcnt_next = tcnt_sum[TCNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= 8'd0;
      t_vec_reg     <= '0;
      tcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      t_vec_reg     <= t;
      tcnt_reg      <= tcnt_next;
    end
  end

  assign Q          = q_reg;
  assign t_vec      = t_vec_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign toggle_cnt = tcnt_reg;

endmodule

// File: tb/tb_dff_using_tff_reg.sv
// Directed bench for dff_using_tff_reg: an arithmetic reference model checked every cycle
// against two instances (TCNT_W=16 and TCNT_W=4), plus hand-computed literal checks.
module tb_dff_using_tff_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_len;
  logic        tcnt_clr;

  logic        ready16, ready4, busy16, busy4, done16, done4;
  logic [7:0]  q16, q4, tv16, tv4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dff_using_tff_reg #(.WIDTH(8), .TCNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready16),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .Q(q16), .t_vec(tv16), .busy(busy16), .done(done16),
    .tcnt_clr(tcnt_clr), .toggle_cnt(cnt16)
  );

  dff_using_tff_reg #(.WIDTH(8), .TCNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready4),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .Q(q4), .t_vec(tv4), .busy(busy4), .done(done4),
    .tcnt_clr(tcnt_clr), .toggle_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register value tracked as a plain number, toggles derived from the change.
  logic [7:0] m_q, m_tv, m_nq;
  int m_phase = 0;  // 0 waiting, 1 counting, 2 completion cycle
  int m_left  = 0;
  int m_cnt16 = 0;
  int m_cnt4  = 0;
  int m_pop;

  always @(posedge clk) begin
    if (rst) begin
      m_q = 8'h00; m_tv = 8'h00; m_cnt16 = 0; m_cnt4 = 0; m_phase = 0; m_left = 0;
    end else begin
      m_nq = m_q;
      case (m_phase)
        0: if (cmd_valid) begin
          case (cmd_op)
            2'b00: m_nq = cmd_data;
            2'b01: m_nq = m_q ^ cmd_data;
            2'b11: m_nq = 8'h00;
            default: m_left = int'(cmd_len);
          endcase
          m_phase = (cmd_op == 2'b10 && cmd_len != 8'd0) ? 1 : 2;
        end
        1: begin
          m_nq = m_q + 8'd1;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
      m_tv  = m_nq ^ m_q;
      m_pop = $countones(m_tv);
      if (tcnt_clr) begin
        m_cnt16 = 0; m_cnt4 = 0;
      end else begin
        m_cnt16 = (m_cnt16 + m_pop > 65535) ? 65535 : m_cnt16 + m_pop;
        m_cnt4  = (m_cnt4 + m_pop > 15) ? 15 : m_cnt4 + m_pop;
      end
      m_q = m_nq;
    end
  end

  initial begin
    wait (chk_en);
    forever begin
      @(posedge clk);
      #1;
      chk("cyc_q16", q16, m_q);
      chk("cyc_q4", q4, m_q);
      chk("cyc_tv16", tv16, m_tv);
      chk("cyc_tv4", tv4, m_tv);
      chk("cyc_busy", {busy16, busy4}, {2{m_phase != 0}});
      chk("cyc_done", {done16, done4}, {2{m_phase == 2}});
      chk("cyc_ready", {ready16, ready4}, {2{m_phase == 0 && !rst}});
      chk("cyc_cnt16", cnt16, m_cnt16);
      chk("cyc_cnt4", cnt4, m_cnt4);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
    while (!ready16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready16) chk("issue_timeout", 0, 1);
    $display("[TB] cmd op=%0d data=%02h len=%0d at %0t", op, data, len, $time);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [7:0] cnt_seq [3] = '{8'hFF, 8'h00, 8'h01};
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; cmd_len = 8'd0; tcnt_clr = 1'b0;

    // 1. reset
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready16, 0);
    chk("rst_q", q16, 8'h00);
    chk("rst_state", {tv16, cnt16, done16, busy16}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", ready16, 1);

    // 2. loads
    issue(2'b00, 8'hA5, 8'd0);
    chk("load_a5_q", q16, 8'hA5);
    chk("load_a5_tv", tv16, 8'hA5);
    chk("load_a5_cnt", cnt16, 4);
    chk("load_a5_done", done16, 1);
    issue(2'b00, 8'h5A, 8'd0);
    chk("load_5a_tv", tv16, 8'hFF);
    chk("load_5a_q", q16, 8'h5A);
    chk("load_5a_cnt", cnt16, 12);

    // 3. count with wrap, then zero-length count
    issue(2'b00, 8'hFE, 8'd0);
    base = int'(cnt16);
    issue(2'b10, 8'h00, 8'd3);
    chk("cnt3_accept_q", q16, 8'hFE);
    chk("cnt3_accept_ready", ready16, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cnt3_seq_q", q16, cnt_seq[k]);
      chk("cnt3_ready", ready16, 0);
      chk("cnt3_done", done16, (k == 2) ? 1 : 0);
    end
    chk("cnt3_toggles", cnt16, base + 10);
    @(negedge clk);
    chk("cnt3_done_once", done16, 0);
    issue(2'b10, 8'h00, 8'd0);
    chk("cnt0_q", q16, 8'h01);
    chk("cnt0_done", done16, 1);

    // 4. toggle, clear, held valid across the completion cycle
    issue(2'b00, 8'h01, 8'd0);
    issue(2'b01, 8'h0F, 8'd0);
    chk("toggle_q", q16, 8'h0E);
    chk("toggle_tv", tv16, 8'h0F);
    issue(2'b11, 8'h00, 8'd0);
    chk("clear_q", q16, 8'h00);
    chk("clear_tv", tv16, 8'h0E);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h0F;
    @(negedge clk);
    cmd_op = 2'b00; cmd_data = 8'h33;
    #1;
    chk("held_done_ready", ready16, 0);
    @(negedge clk);
    chk("held_not_taken_q", q16, 8'h0F);
    chk("held_idle_ready", ready16, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_taken_q", q16, 8'h33);

    // 5. saturation on the narrow counter, then clear racing a load
    @(negedge clk);
    tcnt_clr = 1'b1;
    @(negedge clk);
    tcnt_clr = 1'b0;
    chk("tclr_cnt4", cnt4, 0);
    for (int k = 0; k < 4; k++) begin
      issue(2'b00, 8'hFF, 8'd0);
      issue(2'b00, 8'h00, 8'd0);
    end
    chk("sat_cnt4", cnt4, 15);
    chk("sat_cnt16", cnt16, 60);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h0F; tcnt_clr = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; tcnt_clr = 1'b0;
    chk("clr_load_q", q16, 8'h0F);
    chk("clr_load_cnt4", cnt4, 0);
    chk("clr_load_cnt16", cnt16, 0);

    // 6. reset aborts a running count
    issue(2'b00, 8'h00, 8'd0);
    issue(2'b10, 8'h00, 8'd10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("abort_inc_q", q16, k);
    end
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", ready16, 0);
    @(negedge clk);
    chk("abort_q", q16, 8'h00);
    chk("abort_flags", {done16, busy16}, 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", ready16, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done16, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
